// File: rtl/bomb_game_pkg.sv
// Shared definitions for the defuse-round blocks: timer state encoding, BCD digit
// type, level time presets and small BCD helpers.
package bomb_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOADED  = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_EXPIRED = 3'd4
  } timer_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int TIME_MAX = 99;

  // Level selector presets (90 / 60 / 30 seconds)
  localparam bcd_digit_t LVL_EASY_TENS = 4'd9;
  localparam bcd_digit_t LVL_EASY_ONES = 4'd0;
  localparam bcd_digit_t LVL_MED_TENS  = 4'd6;
  localparam bcd_digit_t LVL_MED_ONES  = 4'd0;
  localparam bcd_digit_t LVL_HARD_TENS = 4'd3;
  localparam bcd_digit_t LVL_HARD_ONES = 4'd0;

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [6:0] bcd_to_bin(input bcd_digit_t tens, input bcd_digit_t ones);
    return ({3'd0, tens} * 7'd10) + {3'd0, ones};
  endfunction

endpackage

// File: rtl/bomb_countdown_timer_if.sv
// Control/data bundle between the level selector / game FSM (master) and the
// countdown timer (slave).
interface bomb_countdown_timer_if;
  import bomb_game_pkg::*;

  logic       load;
  logic       start;
  logic       pause;
  logic       penalty;
  bcd_digit_t tens_in;
  bcd_digit_t ones_in;
  bcd_digit_t tens_out;
  bcd_digit_t ones_out;
  logic       running;
  logic       warning;
  logic       expired;
  logic       expired_pulse;

  modport master (
    output load, start, pause, penalty, tens_in, ones_in,
    input  tens_out, ones_out, running, warning, expired, expired_pulse
  );

  modport slave (
    input  load, start, pause, penalty, tens_in, ones_in,
    output tens_out, ones_out, running, warning, expired, expired_pulse
  );

endinterface

// File: rtl/bomb_countdown_timer_bcd_sat_sub.sv
// Two-digit BCD minus a 7-bit binary amount, saturating at 00, with a zero flag.
module bcd_sat_sub
  import bomb_game_pkg::*;
(
  input  bcd_digit_t tens_i,
  input  bcd_digit_t ones_i,
  input  logic [6:0] amount_i,
  output bcd_digit_t tens_o,
  output bcd_digit_t ones_o,
  output logic       zero_o
);

  logic [6:0] value_s;
  logic [6:0] diff_s;

  // Subtract in binary, then split the result back into two decimal digits.
  always_comb begin
    value_s = bcd_to_bin(tens_i, ones_i);
    if (amount_i >= value_s) begin
      diff_s = 7'd0;
    end else begin
      diff_s = value_s - amount_i;
    end
    tens_o = bcd_digit_t'(diff_s / 7'd10);
    ones_o = bcd_digit_t'(diff_s % 7'd10);
    zero_o = (diff_s == 7'd0);
  end

endmodule

// File: rtl/bomb_countdown_timer.sv
// Two-digit BCD countdown timer: 1 Hz decrement via prescaler, penalty subtraction,
// warning and expiry flags. All outputs come straight from flops.
module bomb_countdown_timer
  import bomb_game_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int PENALTY_SEC   = 5,
  parameter int WARN_SEC      = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  bomb_countdown_timer_if.slave  bus
);

  localparam int PSC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICKS_PER_SEC - 1);

  timer_state_t     state_q, state_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  bcd_digit_t       tens_q, tens_d;
  bcd_digit_t       ones_q, ones_d;
  logic             running_q, running_d;
  logic             warning_q, warning_d;
  logic             expired_q, expired_d;
  logic             expired_pulse_q, expired_pulse_d;

  logic             tick_s;
  logic [6:0]       amount_s;
  bcd_digit_t       sub_tens_s, sub_ones_s;
  logic             sub_zero_s;

  bcd_sat_sub u_sub (
    .tens_i   (tens_q),
    .ones_i   (ones_q),
    .amount_i (amount_s),
    .tens_o   (sub_tens_s),
    .ones_o   (sub_ones_s),
    .zero_o   (sub_zero_s)
  );

  // Seconds to remove this cycle: penalty and the 1 s tick may coincide.
  always_comb begin
    tick_s = (state_q == ST_RUN) && (psc_q == PSC_LAST);
    if (bus.penalty && ((state_q == ST_RUN) || (state_q == ST_PAUSED))) begin
      amount_s = 7'(PENALTY_SEC);
    end else begin
      amount_s = 7'd0;
    end
    if (tick_s) begin
      amount_s = amount_s + 7'd1;
    end else begin
      amount_s = amount_s;
    end
  end

  // Next state and value; priority load > pause > penalty/tick > start.
  always_comb begin
    state_d = state_q;
    psc_d   = psc_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    if (bus.load) begin
      tens_d  = bcd_clamp(bus.tens_in);
      ones_d  = bcd_clamp(bus.ones_in);
      psc_d   = {PSC_W{1'b0}};
      state_d = ST_LOADED;
    end else if (bus.pause && (state_q == ST_RUN)) begin
      state_d = ST_PAUSED;
    end else begin
      if (state_q == ST_RUN) begin
        psc_d = tick_s ? {PSC_W{1'b0}} : psc_q + PSC_W'(1);
      end else begin
        psc_d = psc_q;
      end
      if (amount_s != 7'd0) begin
        tens_d  = sub_tens_s;
        ones_d  = sub_ones_s;
        state_d = sub_zero_s ? ST_EXPIRED : state_q;
      end else if (bus.start && ((state_q == ST_LOADED) || (state_q == ST_PAUSED))) begin
        state_d = ((tens_q == 4'd0) && (ones_q == 4'd0)) ? ST_EXPIRED : ST_RUN;
      end else begin
        state_d = state_q;
      end
    end
  end

  // Status flags are computed from the next state so the flops line up with it.
  always_comb begin
    running_d       = (state_d == ST_RUN);
    warning_d       = ((state_d == ST_RUN) || (state_d == ST_PAUSED)) &&
                      (bcd_to_bin(tens_d, ones_d) < 7'(WARN_SEC));
    expired_d       = (state_d == ST_EXPIRED);
    expired_pulse_d = (state_d == ST_EXPIRED) && (state_q != ST_EXPIRED);
  end

  // State, prescaler, value and output flags with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      psc_q           <= {PSC_W{1'b0}};
      tens_q          <= 4'd0;
      ones_q          <= 4'd0;
      running_q       <= 1'b0;
      warning_q       <= 1'b0;
      expired_q       <= 1'b0;
      expired_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      psc_q           <= psc_d;
      tens_q          <= tens_d;
      ones_q          <= ones_d;
      running_q       <= running_d;
      warning_q       <= warning_d;
      expired_q       <= expired_d;
      expired_pulse_q <= expired_pulse_d;
    end
  end

  assign bus.tens_out      = tens_q;
  assign bus.ones_out      = ones_q;
  assign bus.running       = running_q;
  assign bus.warning       = warning_q;
  assign bus.expired       = expired_q;
  assign bus.expired_pulse = expired_pulse_q;

endmodule

// File: tb/tb_bomb_countdown_timer.sv
// Bench for bomb_countdown_timer: seconds-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_bomb_countdown_timer;
  import bomb_game_pkg::*;

  localparam int T    = 4;
  localparam int PEN  = 5;
  localparam int WARN = 10;

  localparam int M_IDLE = 0, M_LOADED = 1, M_RUN = 2, M_PAUSED = 3, M_EXPIRED = 4;

  typedef struct packed {
    int rem;
    int st;
    int sub;
    bit pulse;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  mdl_t mdl;
  bit   chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  bomb_countdown_timer_if bus ();

  bomb_countdown_timer #(
    .TICKS_PER_SEC (T),
    .PENALTY_SEC   (PEN),
    .WARN_SEC      (WARN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Remaining time in whole seconds; sub = cycles already spent in the current second.
  function automatic mdl_t mdl_step(input mdl_t m, input bit rst_n, input bit ld,
                                    input bit go, input bit hold, input bit pen,
                                    input int t, input int o);
    mdl_t n;
    int   dec;
    n = m;
    n.pulse = 1'b0;
    dec = 0;
    if (!rst_n) begin
      n.rem = 0; n.st = M_IDLE; n.sub = 0;
    end else if (ld) begin
      n.rem = ((t > 9) ? 9 : t) * 10 + ((o > 9) ? 9 : o);
      n.sub = 0;
      n.st  = M_LOADED;
    end else if (m.st == M_RUN && hold) begin
      n.st = M_PAUSED;
    end else begin
      if (pen && (m.st == M_RUN || m.st == M_PAUSED)) dec = dec + PEN;
      if (m.st == M_RUN) begin
        if (m.sub + 1 == T) begin
          dec = dec + 1;
          n.sub = 0;
        end else begin
          n.sub = m.sub + 1;
        end
      end
      if (dec > 0) begin
        n.rem = (m.rem > dec) ? m.rem - dec : 0;
        if (n.rem == 0) begin
          n.st = M_EXPIRED; n.pulse = 1'b1;
        end
      end else if (go && (m.st == M_LOADED || m.st == M_PAUSED)) begin
        if (m.rem == 0) begin
          n.st = M_EXPIRED; n.pulse = 1'b1;
        end else begin
          n.st = M_RUN;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [11:0] exp_vec(input mdl_t m);
    return {4'(m.rem / 10), 4'(m.rem % 10), m.st == M_RUN,
            (m.st == M_RUN || m.st == M_PAUSED) && (m.rem < WARN),
            m.st == M_EXPIRED, m.pulse};
  endfunction

  always @(posedge clk) begin
    mdl <= mdl_step(mdl, rst, bus.load, bus.start, bus.pause, bus.penalty,
                    int'(bus.tens_in), int'(bus.ones_in));
    if (!rst) chk_en <= 1'b1;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ({bus.tens_out, bus.ones_out, bus.running, bus.warning, bus.expired,
           bus.expired_pulse} !== exp_vec(mdl)) begin
        n_err++;
        $display("FAIL per_cycle t=%0t got=%h want=%h (tens,ones,run,warn,exp,pulse)",
                 $time, {bus.tens_out, bus.ones_out, bus.running, bus.warning,
                 bus.expired, bus.expired_pulse}, exp_vec(mdl));
      end
    end
  end

  task automatic chk(input string name, input int t, input int o, input bit r,
                     input bit w, input bit e, input bit p);
    n_cmp++;
    if (bus.tens_out !== 4'(t) || bus.ones_out !== 4'(o) || bus.running !== r ||
        bus.warning !== w || bus.expired !== e || bus.expired_pulse !== p) begin
      n_err++;
      $display("FAIL %s: got %0d%0d run=%0b warn=%0b exp=%0b pulse=%0b, want %0d%0d run=%0b warn=%0b exp=%0b pulse=%0b",
               name, bus.tens_out, bus.ones_out, bus.running, bus.warning, bus.expired,
               bus.expired_pulse, t, o, r, w, e, p);
    end
  endtask

  task automatic drive(input bit l, input bit s, input bit p, input bit n,
                       input logic [3:0] t, input logic [3:0] o);
    bus.load = l; bus.start = s; bus.pause = p; bus.penalty = n;
    bus.tens_in = t; bus.ones_in = o;
    @(negedge clk);
    bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.penalty = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.penalty = 1'b0;
    bus.tens_in = 4'd0; bus.ones_in = 4'd0;
    rst = 1'b0;
    idle(2);
    chk("reset", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // 30 s full countdown
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0);  chk("load30", 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);  chk("start30", 3, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);  chk("no_tick_yet", 3, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);  chk("first_tick", 2, 9, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(36); chk("at20", 2, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);  chk("wrap19", 1, 9, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(40); chk("warn09", 0, 9, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(36); chk("expire", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);  chk("expired_hold", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    // pause keeps the partial second
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(6);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);  chk("paused11", 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);  chk("pause_hold", 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);  chk("resume", 1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);  chk("resume_partial", 1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);  chk("partial_sec", 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);  chk("warn_rise", 0, 9, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);  chk("pause_wins", 0, 9, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);  chk("pen_paused", 0, 4, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);  chk("pen_sat_paused", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);

    // penalty straight to expiry, then everything but load ignored
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);  chk("pen_expire", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);  chk("exp_ignore", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    // penalty coincident with tick; zero load then start
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(3);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);  chk("pen_tick", 5, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);  chk("load00", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);  chk("start00", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);

    // clamping, reset mid-run, reload out of EXPIRED
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 4'hF);  chk("clamp99", 9, 9, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'hC);  chk("clamp_ones", 7, 9, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(5);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 4'd5);  chk("rst_mid", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);  chk("idle_start", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd5);  chk("load_from_exp", 4, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);  chk("pen_loaded_ign", 4, 5, 1'b0, 1'b0, 1'b0, 1'b0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
